// File: rtl/pe_mem_lane_driver_pkg.sv
// Shared namespace codes, FSM state encodings and beat-count helper for the PE memory lane driver.
package pe_mem_lane_driver_pkg;

  localparam logic [1:0] NAMESPACE_MEM_INST   = 2'd0;
  localparam logic [1:0] NAMESPACE_MEM_DATA   = 2'd1;
  localparam logic [1:0] NAMESPACE_MEM_WEIGHT = 2'd2;
  localparam logic [1:0] NAMESPACE_MEM_META   = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Beats needed to carry one word (countEntireData).
  function automatic int count_entire_data(input int data_len, input int mem_data_len);
    return (data_len + mem_data_len - 1) / mem_data_len;
  endfunction

endpackage

// File: rtl/pe_mem_lane_driver_if.sv
// Controller-side command, write-stream and read-back bus of the PE memory lane driver.
interface pe_mem_lane_driver_if #(
  parameter int logNumPeMemLanes = 2,
  parameter int logMemNamespaces = 2,
  parameter int dataLen          = 16,
  parameter int countLen         = 8
);
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic                        cmd_rd;
  logic [logMemNamespaces-1:0] cmd_type;
  logic [logNumPeMemLanes-1:0] cmd_lane;
  logic [countLen-1:0]         cmd_count;
  logic                        wr_data_valid;
  logic                        wr_data_ready;
  logic [dataLen-1:0]          wr_data;
  logic                        rd_data_valid;
  logic [dataLen-1:0]          rd_data;
  logic                        cmd_done;
  logic                        cmd_err;

  modport master (
    output cmd_valid, cmd_rd, cmd_type, cmd_lane, cmd_count, wr_data_valid, wr_data,
    input  cmd_ready, wr_data_ready, rd_data_valid, rd_data, cmd_done, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_rd, cmd_type, cmd_lane, cmd_count, wr_data_valid, wr_data,
    output cmd_ready, wr_data_ready, rd_data_valid, rd_data, cmd_done, cmd_err
  );
endinterface

// File: rtl/pe_mem_beat_serializer.sv
// Splits each accepted word into memDataLen beats, low slice first, one registered beat per cycle.
module pe_mem_beat_serializer
  import pe_mem_lane_driver_pkg::*;
#(
  parameter int dataLen    = 16,
  parameter int memDataLen = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               active,
  input  logic               words_left_nz,
  input  logic               wr_data_valid,
  input  logic [dataLen-1:0] wr_data,
  output logic               wr_data_ready,
  output logic               beat_load,
  output logic               pending,
  output logic               beat_valid,
  output logic [dataLen-1:0] beat_data
);
  localparam int BEATS = count_entire_data(dataLen, memDataLen);
  localparam int PAD   = BEATS * memDataLen;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [PAD-1:0] hold;
  logic [PAD-1:0] padded_in;
  logic [BW-1:0]  beat_idx;
  logic           accept;

  function automatic logic [dataLen-1:0] beat_slice(input logic [PAD-1:0] w, input int idx);
    logic [dataLen-1:0] b;
    b = '0;
    b[memDataLen-1:0] = w[idx*memDataLen +: memDataLen];
    return b;
  endfunction

  assign padded_in     = PAD'(wr_data);
  assign wr_data_ready = active && !pending && words_left_nz;
  assign accept        = wr_data_valid && wr_data_ready;
  assign beat_load     = accept || pending;

  // NOTE: hold is data only, always qualified by pending, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) hold <= padded_in;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_idx   <= '0;
      pending    <= 1'b0;
      beat_valid <= 1'b0;
      beat_data  <= '0;
    end else begin
      beat_valid <= 1'b0;
      beat_data  <= '0;
      if (accept) begin
        // Beat 0 goes straight out so the first beat follows the handshake by one cycle.
        beat_valid <= 1'b1;
        beat_data  <= beat_slice(padded_in, 0);
        beat_idx   <= BW'(1);
        pending    <= (BEATS > 1);
      end else if (pending) begin
        beat_valid <= 1'b1;
        beat_data  <= beat_slice(hold, int'(beat_idx));
        beat_idx   <= beat_idx + 1'b1;
        pending    <= (int'(beat_idx) != BEATS - 1);
      end
    end
  end
endmodule

// File: rtl/pe_mem_lane_driver.sv
// PE memory lane transmitter: command FSM, word counter, lane/type registers and read-back path.
// Build option: define PE_MEM_READBACK_EN to include the weight read-back path.
module pe_mem_lane_driver
  import pe_mem_lane_driver_pkg::*;
#(
  parameter int logNumPeMemLanes = 2,
  parameter int logMemNamespaces = 2,
  parameter int dataLen          = 16,
  parameter int memDataLen       = 16,
  parameter int countLen         = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  pe_mem_lane_driver_if.slave         ctl,
  output logic                        mem_wrt_valid,
  output logic                        mem_weight_rd_valid,
  output logic [logNumPeMemLanes-1:0] peId_mem_out,
  output logic [logMemNamespaces-1:0] mem_data_type,
  output logic [dataLen-1:0]          mem_data_output,
  input  logic [dataLen-1:0]          mem_data_input
);
`ifdef PE_MEM_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  logic [1:0]                  state, state_nx;
  logic [countLen-1:0]         words_left;
  logic [logNumPeMemLanes-1:0] lat_lane;
  logic [logMemNamespaces-1:0] lat_type;
  logic                        err_q, cmd_ready_q;
  logic                        cmd_acc, cmd_bad, wr_hs, beat_load, ser_pending, rd_issue, rd_busy;

  assign cmd_acc       = ctl.cmd_valid && cmd_ready_q;
  assign cmd_bad       = (ctl.cmd_type == logMemNamespaces'(NAMESPACE_MEM_INST)) ||
                         (ctl.cmd_rd && !READBACK);
  assign wr_hs         = ctl.wr_data_valid && ctl.wr_data_ready;
  assign ctl.cmd_ready = cmd_ready_q;
  assign ctl.cmd_done  = (state == ST_DONE);
  assign ctl.cmd_err   = (state == ST_DONE) && err_q;

  pe_mem_beat_serializer #(.dataLen(dataLen), .memDataLen(memDataLen)) u_ser (
    .clk           (clk),
    .reset         (reset),
    .active        (state == ST_WRITE),
    .words_left_nz (words_left != '0),
    .wr_data_valid (ctl.wr_data_valid),
    .wr_data       (ctl.wr_data),
    .wr_data_ready (ctl.wr_data_ready),
    .beat_load     (beat_load),
    .pending       (ser_pending),
    .beat_valid    (mem_wrt_valid),
    .beat_data     (mem_data_output)
  );

  always_comb begin
    // NOTE: default assigned first so no latch is inferred on unlisted paths.
    state_nx = state;
    case (state)
      ST_IDLE: if (cmd_acc) begin
        if (ctl.cmd_count == '0 || cmd_bad) state_nx = ST_DONE;
        else if (ctl.cmd_rd)                state_nx = ST_READ;
        else                                state_nx = ST_WRITE;
      end
      ST_WRITE: if (words_left == '0 && !ser_pending) state_nx = ST_DONE;
      ST_READ:  if (words_left == '0 && !rd_busy)     state_nx = ST_DONE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      words_left    <= '0;
      lat_lane      <= '0;
      lat_type      <= '0;
      err_q         <= 1'b0;
      peId_mem_out  <= '0;
      mem_data_type <= '0;
    end else begin
      state       <= state_nx;
      cmd_ready_q <= (state_nx == ST_IDLE);
      if (cmd_acc) begin
        words_left <= ctl.cmd_count;
        lat_lane   <= ctl.cmd_lane;
        lat_type   <= ctl.cmd_rd ? logMemNamespaces'(NAMESPACE_MEM_WEIGHT) : ctl.cmd_type;
        err_q      <= cmd_bad && (ctl.cmd_count != '0);
      end else if (wr_hs || rd_issue) begin
        words_left <= words_left - 1'b1;
      end
      // Lane and type only move with an issued beat or strobe, so idle cycles keep the last values.
      if (beat_load || rd_issue) begin
        peId_mem_out  <= lat_lane;
        mem_data_type <= lat_type;
      end
    end
  end

`ifdef PE_MEM_READBACK_EN
  logic               strb_q, strb_d, rdv_q;
  logic [dataLen-1:0] rd_q;

  assign rd_issue            = (state == ST_READ) && (words_left != '0);
  assign rd_busy             = strb_q || strb_d;
  assign mem_weight_rd_valid = strb_q;
  assign ctl.rd_data_valid   = rdv_q;
  assign ctl.rd_data         = rd_q;

  // The PE answers one cycle after the strobe; strb_d marks the cycle its data is on the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      strb_q <= 1'b0;
      strb_d <= 1'b0;
      rdv_q  <= 1'b0;
      rd_q   <= '0;
    end else begin
      strb_q <= rd_issue;
      strb_d <= strb_q;
      rdv_q  <= strb_d;
      rd_q   <= strb_d ? mem_data_input : '0;
    end
  end
`else
  logic unused_rd_input;

  assign rd_issue            = 1'b0;
  assign rd_busy             = 1'b0;
  assign mem_weight_rd_valid = 1'b0;
  assign ctl.rd_data_valid   = 1'b0;
  assign ctl.rd_data         = '0;
  assign unused_rd_input     = ^mem_data_input;
`endif
endmodule

// File: doc/pe_mem_lane_driver.md
# pe_mem_lane_driver

Memory-side transmitter for the PE memory lanes. Accepts burst commands plus a word stream from the memory controller and serializes each `dataLen` word into `memDataLen` beats. It drives the lane write strobe, lane id and namespace type that every PE memory interface on the lane decodes. It also issues weight read-back strobes and returns the weights the addressed PE drives back one cycle later.

## Interface
Parameters:
- `logNumPeMemLanes`, 2: lane-id width.
- `logMemNamespaces`, 2: namespace-type width.
- `dataLen`, 16: word width.
- `memDataLen`, 16: beat width; `countEntireData = ceil(dataLen/memDataLen)`.
- `countLen`, 8: burst-length width.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` / `cmd_ready` in/out 1: command handshake.
- `cmd_rd` in 1: 1 selects weight read-back, 0 selects write.
- `cmd_type` in `logMemNamespaces`: `NAMESPACE_MEM_DATA`, `_WEIGHT` or `_META`.
- `cmd_lane` in `logNumPeMemLanes`: target lane.
- `cmd_count` in `countLen`: words in the burst.
- `wr_data_valid` / `wr_data_ready` in/out 1, `wr_data` in `dataLen`: write word stream.
- `rd_data_valid` out 1, `rd_data` out `dataLen`: read-back words, no backpressure.
- `cmd_done` out 1: one-cycle pulse when a command completes. `cmd_err` out 1: pulse alongside `cmd_done` for a rejected command.
- `mem_wrt_valid`, `mem_weight_rd_valid` out 1; `peId_mem_out` out `logNumPeMemLanes`; `mem_data_type` out `logMemNamespaces`; `mem_data_output` out `dataLen`: to the PEs.
- `mem_data_input` in `dataLen`: read-back data from the PEs.

## Operation
- FSM states: IDLE, WRITE, READ, DONE. `cmd_ready` is 1 only in IDLE.
- On command accept, latch `cmd_rd`, `cmd_type`, `cmd_lane` and `cmd_count`, and load the word counter.
- From IDLE:
  - `cmd_count == 0` → DONE.
  - `cmd_type == NAMESPACE_MEM_INST` → DONE with `cmd_err`.
  - Otherwise → READ if `cmd_rd`, else WRITE.
- WRITE:
  - Hold register takes `wr_data` on handshake.
  - Beats are issued low slice first: beat k = `word[k*memDataLen +: memDataLen]`; the top slice is zero-padded. Upper bits of `mem_data_output` are 0.
  - Each beat asserts `mem_wrt_valid` with the latched lane and type.
  - `wr_data_ready` = WRITE && (hold empty || last beat issuing this cycle) && words remaining.
  - After the last beat of the last word → DONE.
- READ:
  - Assert `mem_weight_rd_valid` for `cmd_count` consecutive cycles, with `mem_data_type = NAMESPACE_MEM_WEIGHT`.
  - Register `mem_data_input` one cycle after each strobe.
  - Go to DONE after the final capture.
- DONE: pulse `cmd_done` for one cycle → IDLE.
- Lane id and type are constant for a whole burst, so the receiver's beat counter never sees a mixed-type word.
- When no beat is issued, `mem_wrt_valid = 0` and `mem_data_output = 0`; lane and type hold their last values.

## Timing
- Reset: all outputs 0, state IDLE. `cmd_ready` goes to 1 the cycle after reset deasserts.
- All PE-facing outputs are registered.
- Write latency: `wr_data` handshake in cycle t → beat 0 in t+1, beat k in t+1+k.
- Write throughput: one beat per cycle, no bubbles while `wr_data_valid` stays high. A `wr_data_valid` gap inserts idle cycles only between words, never between beats of one word.
- Read latency: strobe in cycle t → PE data in t+1 → `rd_data_valid` in t+2.
- `cmd_done` timing:
  - Write: one cycle after the last beat.
  - Read: one cycle after the last capture.
  - Zero-count or error command: one cycle after accept.
- Reset mid-burst: outputs clear next cycle and the command is dropped. Partial PE collections are cleared by the shared reset.

## Configuration
- `PE_MEM_READBACK_EN` defined: READ state, read-back capture and the `rd_data` path are present.
- `PE_MEM_READBACK_EN` undefined:
  - `cmd_rd = 1` commands complete with `cmd_err`.
  - `mem_weight_rd_valid`, `rd_data_valid` and `rd_data` are tied 0.
  - `mem_data_input` is unused.

## Structure
- Namespace codes stay in `inst.vh`. FSM state encodings and `countEntireData` derivation go in a shared header with the `C_LOG_2` macro from `log.vh`.
- Word and beat counters use `Cnter`.
- One sub-module: `pe_mem_beat_serializer` (hold register, beat counter, slice mux, `wr_data_ready`).

## Test plan
Parameters for all scenarios: `dataLen=32`, `memDataLen=16`.
- Write, lane 2, DATA, count 2, words 0xAAAA5555 and 0x12345678 → beats 0x5555, 0xAAAA, 0x5678, 0x1234 on consecutive cycles with `peId_mem_out=2`; `cmd_done` one cycle after beat 4.
- `wr_data_valid` dropped for 3 cycles after word 1 → 3-cycle gap between beat 2 and beat 3, none inside a word.
- Read, lane 1, count 3, PE returns 0x11, 0x22, 0x33 → `rd_data_valid` at t+2..t+4 with those values.
- `cmd_count=0` → `cmd_done` one cycle after accept, no strobes. `cmd_type=INST` → `cmd_done` with `cmd_err`.
- `reset` asserted after beat 1 of a 4-word write → all strobes 0 next cycle; `cmd_ready=1` after release.
- `PE_MEM_READBACK_EN` undefined, read command → `cmd_err` pulse, `mem_weight_rd_valid` never asserted.
